// File: rtl/corrige_hamming_pkg.sv
// Shared definitions for the Hamming(15,11) decoder: widths, bit layout and syndrome helpers.
package corrige_hamming_pkg;

    localparam int LARG_CODIGO = 15;
    localparam int LARG_DADO   = 11;
    localparam int LARG_SIND   = 4;

    // 1-based codeword positions of the parity bits
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;
    localparam int POS_P8 = 8;

    typedef logic [LARG_CODIGO-1:0] codigo_t;
    typedef logic [LARG_DADO-1:0]   dado_t;
    typedef logic [LARG_SIND-1:0]   sind_t;

    function automatic bit eh_paridade(input int pos);
        return (pos == POS_P1) || (pos == POS_P2) || (pos == POS_P4) || (pos == POS_P8);
    endfunction

    // 1-based position of data bit di: the i-th non-parity position
    function automatic int pos_dado(input int i);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int k = 1; k <= LARG_CODIGO; k++) begin
            if (!eh_paridade(k)) begin
                if (n == i) r = k;
                n++;
            end
        end
        return r;
    endfunction

    // Codeword bits covered by syndrome bit j (positions with bit j set)
    function automatic codigo_t mascara_sindrome(input int j);
        codigo_t m;
        m = '0;
        for (int k = 1; k <= LARG_CODIGO; k++) begin
            m[k-1] = ((k >> j) & 1) != 0;
        end
        return m;
    endfunction

    function automatic sind_t calc_sindrome(input codigo_t c);
        sind_t s;
        for (int j = 0; j < LARG_SIND; j++) begin
            s[j] = ^(c & mascara_sindrome(j));
        end
        return s;
    endfunction

endpackage

// File: rtl/corrige_hamming_sindrome.sv
// Combinational 15->4 Hamming syndrome; the value equals the 1-based position of a single flipped bit.
module sindrome_hamming
    import corrige_hamming_pkg::*;
(
    input  logic [LARG_CODIGO-1:0] codigo,
    output logic [LARG_SIND-1:0]   sindrome
);

    genvar gi;
    generate
        for (gi = 0; gi < LARG_SIND; gi++) begin : g_bit
            localparam codigo_t MASCARA = mascara_sindrome(gi);
            assign sindrome[gi] = ^(codigo & MASCARA);
        end
    endgenerate

endmodule

// File: rtl/corrige_hamming.sv
// Two-stage streaming Hamming(15,11) decoder: S1 registers word+syndrome, S2 corrects and extracts data.
module corrige_hamming
    import corrige_hamming_pkg::*;
#(
    parameter int LARGURA_CONTADOR = 16
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LARG_CODIGO-1:0]      entrada,
    input  logic                        entrada_valida,
    output logic                        entrada_pronta,
    output logic [LARG_DADO-1:0]        saida,
    output logic                        saida_valida,
    input  logic                        saida_pronta,
    output logic [LARG_SIND-1:0]        sindrome,
    output logic                        erro_corrigido,
    input  logic                        limpa_contador,
    output logic [LARGURA_CONTADOR-1:0] contador_erros
);

    localparam logic [LARGURA_CONTADOR-1:0] CONT_MAX = '1;

    logic                        v1_reg;
    codigo_t                     codigo1_reg;
    sind_t                       sind1_reg;
    logic                        v2_reg;
    dado_t                       saida_reg;
    sind_t                       sind2_reg;
    logic                        erro2_reg;
    logic [LARGURA_CONTADOR-1:0] contador_reg;

    sind_t   sind_entrada;
    codigo_t codigo_corrigido;
    dado_t   dado_next;
    logic    pronta2;

    sindrome_hamming u_sindrome (
        .codigo   (entrada),
        .sindrome (sind_entrada)
    );

    // S2 can load when empty or when its word leaves this cycle
    assign pronta2        = !v2_reg || saida_pronta;
    assign entrada_pronta = !v1_reg || pronta2;

    genvar gi;
    generate
        // Syndrome 0 matches no position, so a clean word passes untouched
        for (gi = 0; gi < LARG_CODIGO; gi++) begin : g_corrige
            assign codigo_corrigido[gi] = codigo1_reg[gi] ^ (sind1_reg == LARG_SIND'(gi + 1));
        end
        for (gi = 0; gi < LARG_DADO; gi++) begin : g_extrai
            localparam int POS = pos_dado(gi);
            assign dado_next[gi] = codigo_corrigido[POS-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg       <= 1'b0;
            codigo1_reg  <= '0;
            sind1_reg    <= '0;
            v2_reg       <= 1'b0;
            saida_reg    <= '0;
            sind2_reg    <= '0;
            erro2_reg    <= 1'b0;
            contador_reg <= '0;
        end else begin
            if (entrada_pronta) begin
                v1_reg <= entrada_valida;
                if (entrada_valida) begin
                    codigo1_reg <= entrada;
                    sind1_reg   <= sind_entrada;
                end
            end
            if (pronta2) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    saida_reg <= dado_next;
                    sind2_reg <= sind1_reg;
                    erro2_reg <= (sind1_reg != '0);
                end
            end
            if (limpa_contador) begin
                contador_reg <= '0;
            end else if (v2_reg && saida_pronta && erro2_reg && (contador_reg != CONT_MAX)) begin
                contador_reg <= contador_reg + 1'b1;
            end
        end
    end

    assign saida          = saida_reg;
    assign saida_valida   = v2_reg;
    assign sindrome       = sind2_reg;
    assign erro_corrigido = erro2_reg;
    assign contador_erros = contador_reg;

endmodule

// File: tb/tb_corrige_hamming.sv
// Self-checking bench for corrige_hamming: vector table, scoreboard queue, backpressure/counter/reset sequences.
module tb_corrige_hamming;

    localparam int W_CONT   = 3;
    localparam int CONT_MAX = 7;

    logic              clk;
    logic              rst;
    logic [14:0]       entrada;
    logic              entrada_valida;
    logic              entrada_pronta;
    logic [10:0]       saida;
    logic              saida_valida;
    logic              saida_pronta;
    logic [3:0]        sindrome;
    logic              erro_corrigido;
    logic              limpa_contador;
    logic [W_CONT-1:0] contador_erros;

    corrige_hamming #(.LARGURA_CONTADOR(W_CONT)) dut (
        .clk            (clk),
        .rst            (rst),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .sindrome       (sindrome),
        .erro_corrigido (erro_corrigido),
        .limpa_contador (limpa_contador),
        .contador_erros (contador_erros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] d;
        logic [3:0]  s;
        logic        e;
    } esperado_t;

    typedef struct {
        logic [14:0] cw;
        logic [10:0] d;
        logic [3:0]  s;
        logic        e;
    } vetor_t;

    esperado_t   fila[$];
    int          n_verif    = 0;
    int          n_falhas   = 0;
    int          cont_modelo = 0;
    bit          verboso    = 0;
    bit          em_stall   = 0;
    logic [10:0] stall_saida;
    logic [3:0]  stall_sind;
    logic        stall_erro;
    logic [10:0] exp_d;
    logic [3:0]  exp_s;
    logic        exp_e;

    task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_verif++;
        if (atual !== esperado) begin
            n_falhas++;
            $display("FAIL %s: atual=%0h esperado=%0h", nome, atual, esperado);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions in order, then parities
    function automatic logic [14:0] codifica(input logic [10:0] d);
        logic [14:0] c;
        int i;
        logic p;
        c = '0;
        i = 0;
        for (int k = 1; k <= 15; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k-1] = d[i];
                i++;
            end
        end
        for (int j = 1; j <= 8; j = j * 2) begin
            p = 1'b0;
            for (int k = 1; k <= 15; k++) if ((k & j) != 0) p = p ^ c[k-1];
            c[j-1] = p;
        end
        return c;
    endfunction

    task automatic prepara(input logic [10:0] d, input int f);
        logic [14:0] m;
        m = '0;
        if (f != 0) m[f-1] = 1'b1;
        entrada = codifica(d) ^ m;
        exp_d   = d;
        exp_s   = f[3:0];
        exp_e   = (f != 0);
    endtask

    // One clock: monitor/scoreboard at the falling edge, then return just after the rising edge
    task automatic passo(output bit aceito);
        esperado_t r;
        bit transf_erro;
        @(negedge clk);
        aceito      = 1'b0;
        transf_erro = 1'b0;
        if (rst) begin
            fila.delete();
            cont_modelo = 0;
            em_stall    = 1'b0;
        end else begin
            if (em_stall) begin
                confere("estavel_valida", saida_valida, 1);
                confere("estavel_saida", saida, stall_saida);
                confere("estavel_sindrome", sindrome, stall_sind);
                confere("estavel_erro", erro_corrigido, stall_erro);
            end
            confere("contador_erros", contador_erros, cont_modelo);
            aceito = entrada_valida && entrada_pronta;
            if (aceito) fila.push_back('{exp_d, exp_s, exp_e});
            if (saida_valida && saida_pronta) begin
                if (fila.size() == 0) begin
                    n_verif++;
                    n_falhas++;
                    $display("FAIL saida_extra: atual=%0h esperado=nenhuma", saida);
                end else begin
                    r = fila.pop_front();
                    confere("saida", saida, r.d);
                    confere("sindrome", sindrome, r.s);
                    confere("erro_corrigido", erro_corrigido, r.e);
                    transf_erro = r.e;
                    if (verboso)
                        $display("transacao: saida=%03h sindrome=%0d erro=%0b (esperado %03h/%0d/%0b)",
                                 saida, sindrome, erro_corrigido, r.d, r.s, r.e);
                end
            end
            if (limpa_contador) cont_modelo = 0;
            else if (transf_erro && cont_modelo != CONT_MAX) cont_modelo++;
            em_stall    = saida_valida && !saida_pronta;
            stall_saida = saida;
            stall_sind  = sindrome;
            stall_erro  = erro_corrigido;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic envia();
        bit ac;
        int guarda;
        entrada_valida = 1'b1;
        ac = 1'b0;
        guarda = 0;
        while (!ac && guarda < 50) begin
            passo(ac);
            guarda++;
        end
        if (!ac) begin
            n_verif++;
            n_falhas++;
            $display("FAIL envia_timeout: atual=nao_aceito esperado=aceito");
        end
    endtask

    task automatic drena();
        bit ac;
        int guarda;
        entrada_valida = 1'b0;
        guarda = 0;
        while ((fila.size() != 0 || saida_valida) && guarda < 50) begin
            passo(ac);
            guarda++;
        end
        n_verif++;
        if (fila.size() != 0) begin
            n_falhas++;
            $display("FAIL drena_timeout: atual=%0d pendentes esperado=0", fila.size());
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: atual=tempo_esgotado esperado=fim");
        $fatal(1, "simulation time limit");
    end

    initial begin : teste
        vetor_t tabela[7];
        bit ac;
        int k;
        int f;
        int guarda;

        tabela[0] = '{15'h0000, 11'h000, 4'd0,  1'b0};
        tabela[1] = '{15'h7FFF, 11'h7FF, 4'd0,  1'b0};
        tabela[2] = '{15'h0007, 11'h001, 4'd0,  1'b0};
        tabela[3] = '{15'h7FDF, 11'h7FF, 4'd6,  1'b1};
        tabela[4] = '{15'h4007, 11'h001, 4'd15, 1'b1};
        tabela[5] = '{15'h0006, 11'h001, 4'd1,  1'b1};
        tabela[6] = '{15'h0008, 11'h000, 4'd4,  1'b1};

        rst = 1'b1;
        entrada = '0;
        entrada_valida = 1'b0;
        saida_pronta = 1'b1;
        limpa_contador = 1'b0;
        exp_d = '0;
        exp_s = '0;
        exp_e = 1'b0;
        passo(ac);
        passo(ac);
        rst = 1'b0;
        #1;
        confere("reset_saida_valida", saida_valida, 0);
        confere("reset_saida", saida, 0);
        confere("reset_sindrome", sindrome, 0);
        confere("reset_erro", erro_corrigido, 0);
        confere("reset_contador", contador_erros, 0);
        confere("reset_entrada_pronta", entrada_pronta, 1);

        // Vector table, back to back
        verboso = 1'b1;
        for (int i = 0; i < 7; i++) begin
            entrada = tabela[i].cw;
            exp_d   = tabela[i].d;
            exp_s   = tabela[i].s;
            exp_e   = tabela[i].e;
            envia();
        end
        drena();
        verboso = 1'b0;
        confere("contador_tabela", contador_erros, 4);

        // Latency: accepted at edge N, visible on saida after N+1
        prepara(11'h2A5, 9);
        envia();
        entrada_valida = 1'b0;
        confere("latencia_vazia", saida_valida, 0);
        passo(ac);
        confere("latencia_valida", saida_valida, 1);
        confere("latencia_saida", saida, 11'h2A5);
        drena();

        // Exhaustive data words, all flip positions covered, random handshakes
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 2048; d++) begin
                f = (p == 0) ? (d % 16) : ((d * 7 + 3) % 16);
                prepara(11'(d), f);
                ac = 1'b0;
                guarda = 0;
                while (!ac && guarda < 100) begin
                    entrada_valida = ($urandom_range(0, 3) != 0);
                    if (!entrada_valida) entrada = 15'($urandom);
                    else prepara(11'(d), f);
                    saida_pronta = ($urandom_range(0, 3) != 0);
                    passo(ac);
                    guarda++;
                end
                if (!ac) begin
                    n_verif++;
                    n_falhas++;
                    $display("FAIL exaustivo_timeout: atual=nao_aceito esperado=aceito");
                end
            end
        end
        saida_pronta = 1'b1;
        drena();

        // Backpressure: two words absorbed, then input blocked until release
        saida_pronta = 1'b0;
        k = 0;
        prepara(11'(k * 37), 0);
        entrada_valida = 1'b1;
        for (int c = 0; c < 5; c++) begin
            passo(ac);
            confere("bp_aceite", ac, (c < 2) ? 1 : 0);
            if (ac) begin
                k++;
                prepara(11'(k * 37), k % 16);
            end
        end
        saida_pronta = 1'b1;
        for (int c = 0; c < 6; c++) begin
            passo(ac);
            confere("bp_retoma", ac, 1);
            confere("bp_saida_valida", saida_valida, 1);
            if (ac) begin
                k++;
                prepara(11'(k * 37), k % 16);
            end
        end
        drena();

        // Counter saturation
        limpa_contador = 1'b1;
        passo(ac);
        limpa_contador = 1'b0;
        for (int i = 0; i < 10; i++) begin
            prepara(11'(i * 101), (i % 15) + 1);
            envia();
        end
        drena();
        confere("contador_saturado", contador_erros, 7);

        // Clear wins over a same-cycle erroneous transfer
        saida_pronta = 1'b0;
        prepara(11'h155, 3);
        envia();
        entrada_valida = 1'b0;
        passo(ac);
        confere("limpa_palavra_parada", saida_valida, 1);
        saida_pronta = 1'b1;
        limpa_contador = 1'b1;
        passo(ac);
        limpa_contador = 1'b0;
        confere("limpa_prioridade", contador_erros, 0);
        drena();

        // Reset mid-stream discards everything in flight
        for (int i = 0; i < 3; i++) begin
            prepara(11'(i + 1), 12);
            envia();
        end
        prepara(11'h7AA, 5);
        entrada_valida = 1'b1;
        rst = 1'b1;
        passo(ac);
        rst = 1'b0;
        entrada_valida = 1'b0;
        confere("rst_meio_saida_valida", saida_valida, 0);
        confere("rst_meio_contador", contador_erros, 0);
        confere("rst_meio_entrada_pronta", entrada_pronta, 1);
        for (int i = 0; i < 4; i++) passo(ac);
        confere("rst_meio_sem_saida", saida_valida, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

endmodule
